// File: rtl/keymap_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : keymap_access_arbiter
// Description : Single-port sequencer for the keyboard keymap RAM, shared by
//               the scancode translator (4-byte lookup bursts), the CPU
//               keymap register port (auto-incrementing byte access) and the
//               boot-time keymap loader (byte stream from flash).
// Ports       : clk/rst_n        - clock, asynchronous active-low reset
//               tr_*             - translator request, base and byte returns
//               cpu_*            - CPU strobes, data, rewind, status
//               ld_*             - loader start, byte handshake, status
//               ram_*            - keymap RAM address/write/read-data port
// Revision    : 1.0 - initial release
// ============================================================================
module keymap_access_arbiter #(
    parameter int AW   = 14,
    parameter int DW   = 8,
    parameter int FAIR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    // translator
    input  logic          tr_req,
    input  logic [AW-3:0] tr_base,
    output logic          tr_valid,
    output logic [1:0]    tr_idx,
    output logic [DW-1:0] tr_data,
    output logic          tr_done,
    // CPU register port
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_rewind,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_busy,
    output logic          cpu_err,
    // keymap loader
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    // keymap RAM
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TR_ADDR    = 3'd1,
        S_TR_DRAIN   = 3'd2,
        S_CPU_RD     = 3'd3,
        S_CPU_RDDATA = 3'd4,
        S_CPU_WR     = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_addr_max = {AW{1'b1}};

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_idx;
    logic [1:0]      w_next_idx;
    logic [AW-3:0]   r_tr_base;
    logic            r_tr_valid;
    logic [1:0]      r_tr_idx;
    logic            r_last_tr;
    logic            r_cpu_pend;
    logic            r_cpu_pend_wr;
    logic [DW-1:0]   r_cpu_wdata;
    logic [DW-1:0]   r_cpu_dout;
    logic            r_cpu_err;
    logic [AW-1:0]   r_cpu_addr;
    logic            r_ld_busy;
    logic            r_ld_done;
    logic [AW-1:0]   r_ld_addr;

    logic            w_strobe;
    logic            w_cpu_busy;
    logic            w_cpu_first;
    logic            w_grant_tr;
    logic            w_grant_cpu;
    logic            w_ld_ready;
    logic            w_ld_wr;
    logic            w_cpu_step;

    assign w_strobe    = cpu_rd | cpu_wr;
    // A pending access stays pending until its last state, so the pending
    // flag alone covers both "waiting" and "in progress".
    assign w_cpu_busy  = r_cpu_pend;
    // Fairness: after a translator burst, a waiting CPU access goes first.
    assign w_cpu_first = (FAIR != 0) && r_last_tr && r_cpu_pend;
    assign w_grant_tr  = (r_state == S_IDLE) && tr_req && !w_cpu_first;
    assign w_grant_cpu = (r_state == S_IDLE) && r_cpu_pend && !w_grant_tr;
    assign w_ld_ready  = (r_state == S_IDLE) && r_ld_busy && !tr_req && !r_cpu_pend;
    assign w_ld_wr     = w_ld_ready && ld_valid;
    // The CPU address advances (and the access retires) in the last state.
    assign w_cpu_step  = (r_state == S_CPU_RDDATA) || (r_state == S_CPU_WR);

    // Next state and RAM port
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_tr) begin
                    w_next_state = S_TR_ADDR;
                    w_next_idx   = 2'd0;
                end else if (w_grant_cpu) begin
                    w_next_state = r_cpu_pend_wr ? S_CPU_WR : S_CPU_RD;
                end else if (w_ld_wr) begin
                    ram_addr  = r_ld_addr;
                    ram_we    = 1'b1;
                    ram_wdata = ld_data;
                end
            end
            S_TR_ADDR: begin
                ram_addr   = {r_tr_base, r_idx};
                w_next_idx = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_next_state = S_TR_DRAIN;
                end
            end
            S_TR_DRAIN: begin
                w_next_state = S_IDLE;
            end
            S_CPU_RD: begin
                ram_addr     = r_cpu_addr;
                w_next_state = S_CPU_RDDATA;
            end
            S_CPU_RDDATA: begin
                w_next_state = S_IDLE;
            end
            S_CPU_WR: begin
                ram_addr     = r_cpu_addr;
                ram_we       = 1'b1;
                ram_wdata    = r_cpu_wdata;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_tr_base     <= '0;
            r_tr_valid    <= 1'b0;
            r_tr_idx      <= 2'd0;
            r_last_tr     <= 1'b0;
            r_cpu_pend    <= 1'b0;
            r_cpu_pend_wr <= 1'b0;
            r_cpu_wdata   <= '0;
            r_cpu_dout    <= '0;
            r_cpu_err     <= 1'b0;
            r_cpu_addr    <= '0;
            r_ld_busy     <= 1'b0;
            r_ld_done     <= 1'b0;
            r_ld_addr     <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;

            // Base is captured at grant so the burst is immune to tr_base
            // changing after the requester drops tr_req.
            if (w_grant_tr) begin
                r_tr_base <= tr_base;
            end

            // Read data for an address returns one cycle later: delay the
            // beat qualifier and index by one cycle to line up with it.
            r_tr_valid <= (r_state == S_TR_ADDR);
            r_tr_idx   <= (r_state == S_TR_ADDR) ? r_idx : 2'd0;

            if (w_grant_tr) begin
                r_last_tr <= 1'b1;
            end else if (w_grant_cpu) begin
                r_last_tr <= 1'b0;
            end

            // Write wins over a simultaneous read.
            if (w_strobe && !w_cpu_busy) begin
                r_cpu_pend    <= 1'b1;
                r_cpu_pend_wr <= cpu_wr;
                r_cpu_wdata   <= cpu_din;
            end else if (w_cpu_step) begin
                r_cpu_pend    <= 1'b0;
            end

            if (w_strobe && w_cpu_busy) begin
                r_cpu_err <= 1'b1;
            end else if (cpu_rewind) begin
                r_cpu_err <= 1'b0;
            end

            // Rewind beats a same-cycle increment.
            if (cpu_rewind) begin
                r_cpu_addr <= '0;
            end else if (w_cpu_step) begin
                r_cpu_addr <= r_cpu_addr + c_addr_one;
            end

            if (r_state == S_CPU_RDDATA) begin
                r_cpu_dout <= ram_rdata;
            end

            r_ld_done <= 1'b0;
            if (ld_start) begin
                r_ld_busy <= 1'b1;
                r_ld_addr <= '0;
            end else if (w_ld_wr) begin
                r_ld_addr <= r_ld_addr + c_addr_one;
                if (r_ld_addr == c_addr_max) begin
                    r_ld_busy <= 1'b0;
                    r_ld_done <= 1'b1;
                end
            end
        end
    end

    assign tr_valid = r_tr_valid;
    assign tr_idx   = r_tr_idx;
    assign tr_data  = r_tr_valid ? ram_rdata : '0;
    assign tr_done  = (r_state == S_TR_DRAIN);
    assign cpu_dout = r_cpu_dout;
    assign cpu_busy = w_cpu_busy;
    assign cpu_err  = r_cpu_err;
    assign ld_ready = w_ld_ready;
    assign ld_busy  = r_ld_busy;
    assign ld_done  = r_ld_done;

endmodule
`default_nettype wire

// File: tb/tb_keymap_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_keymap_access_arbiter
// Description : Self-checking bench for keymap_access_arbiter with a keymap
//               RAM model, vector tables, a full keymap load, randomized
//               CPU/translator traffic against a shadow keymap, and the
//               address-wrap and mid-burst reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keymap_access_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tr_req;
    logic [AW-3:0] tr_base;
    logic          tr_valid;
    logic [1:0]    tr_idx;
    logic [DW-1:0] tr_data;
    logic          tr_done;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [DW-1:0] cpu_din;
    logic          cpu_rewind;
    logic [DW-1:0] cpu_dout;
    logic          cpu_busy;
    logic          cpu_err;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    keymap_access_arbiter #(.AW(AW), .DW(DW), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .tr_req(tr_req), .tr_base(tr_base), .tr_valid(tr_valid),
        .tr_idx(tr_idx), .tr_data(tr_data), .tr_done(tr_done),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .cpu_rewind(cpu_rewind), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .cpu_err(cpu_err),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Keymap RAM model: synchronous read, one-cycle latency, with a
    // bench-side preload port.
    logic [DW-1:0] mem [DEPTH];
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [DW-1:0] bk_data;
    always @(posedge clk) begin
        if (bk_we)       mem[bk_addr]  <= bk_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Expected keymap contents.
    logic [7:0] exp_mem [DEPTH];

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached before the summary line");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [13:0] v;
        v = a[13:0];
        return v[7:0] ^ {2'b00, v[13:8]} ^ 8'h5A;
    endfunction

    task automatic wait_cpu_idle(input string name);
        int n;
        n = 0;
        while (cpu_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (cpu_busy) chk(name, 32'(cpu_busy), 32'd0);
    endtask

    // op: 0 rewind, 1 write, 2 read, 3 read+write together. Called at a negedge.
    task automatic cpu_op(input int op, input logic [7:0] din);
        if (op == 0) begin
            cpu_rewind = 1'b1;
            @(negedge clk);
            cpu_rewind = 1'b0;
        end else begin
            cpu_rd  = (op == 2) || (op == 3);
            cpu_wr  = (op == 1) || (op == 3);
            cpu_din = din;
            @(negedge clk);
            cpu_rd  = 1'b0;
            cpu_wr  = 1'b0;
            wait_cpu_idle("cpu access completes");
        end
    endtask

    typedef struct {
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic          valid;
        logic [1:0]    idx;
        logic [7:0]    data;
        logic          done;
    } trv_t;

    typedef struct {
        int            op;
        logic [7:0]    din;
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } cpv_t;

    trv_t trv [6];
    cpv_t cpv [6];

    initial begin
        int d1, d2, bf, cnt, n_done;
        logic pulsed, prev_busy, burst, inj_done;

        // burst for tr_base 0x025, one row per cycle after the grant cycle
        trv[0] = '{1'b1, 14'h094, 1'b0, 2'd0, 8'h00, 1'b0};
        trv[1] = '{1'b1, 14'h095, 1'b1, 2'd0, 8'h11, 1'b0};
        trv[2] = '{1'b1, 14'h096, 1'b1, 2'd1, 8'h22, 1'b0};
        trv[3] = '{1'b1, 14'h097, 1'b1, 2'd2, 8'h33, 1'b0};
        trv[4] = '{1'b0, 14'h000, 1'b1, 2'd3, 8'h44, 1'b1};
        trv[5] = '{1'b0, 14'h000, 1'b0, 2'd0, 8'h00, 1'b0};
        // CPU sequence: rewind, wr A5, wr 5A, rewind, rd, rd
        cpv[0] = '{0, 8'h00, 14'h0000, 8'h00};
        cpv[1] = '{1, 8'hA5, 14'h0000, 8'hA5};
        cpv[2] = '{1, 8'h5A, 14'h0001, 8'h5A};
        cpv[3] = '{0, 8'h00, 14'h0000, 8'h00};
        cpv[4] = '{2, 8'h00, 14'h0000, 8'hA5};
        cpv[5] = '{2, 8'h00, 14'h0001, 8'h5A};

        rst_n = 1'b0; tr_req = 1'b0; tr_base = '0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = '0; cpu_rewind = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;

        // preload 0x094..0x097 while in reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bk_we = 1'b1; bk_addr = 14'h094 + 14'(i); bk_data = 8'(8'h11 * (i + 1));
        end
        @(negedge clk);
        bk_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("reset tr_valid", 32'(tr_valid), 0);
        chk("reset tr_done", 32'(tr_done), 0);
        chk("reset cpu_busy", 32'(cpu_busy), 0);
        chk("reset cpu_err", 32'(cpu_err), 0);
        chk("reset cpu_dout", 32'(cpu_dout), 0);
        chk("reset ld_busy", 32'(ld_busy), 0);
        chk("reset ld_ready", 32'(ld_ready), 0);
        chk("reset ld_done", 32'(ld_done), 0);
        chk("reset ram_we", 32'(ram_we), 0);
        chk("reset ram_addr", 32'(ram_addr), 0);

        // translator burst; tr_req dropped mid-burst must not cut it short
        tr_req = 1'b1; tr_base = 12'h025;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (trv[i].chk_addr) chk("burst ram_addr", 32'(ram_addr), 32'(trv[i].addr));
            chk("burst ram_we", 32'(ram_we), 0);
            chk("burst tr_valid", 32'(tr_valid), 32'(trv[i].valid));
            if (trv[i].valid) begin
                chk("burst tr_idx", 32'(tr_idx), 32'(trv[i].idx));
                chk("burst tr_data", 32'(tr_data), 32'(trv[i].data));
            end
            chk("burst tr_done", 32'(tr_done), 32'(trv[i].done));
            if (i == 1) tr_req = 1'b0;
        end

        // CPU register port table
        for (int i = 0; i < 6; i++) begin
            cpu_op(cpv[i].op, cpv[i].din);
            if (cpv[i].op == 1) chk("cpu write reaches RAM", 32'(mem[cpv[i].addr]), 32'(cpv[i].exp));
            if (cpv[i].op == 2) chk("cpu read dout", 32'(cpu_dout), 32'(cpv[i].exp));
            chk("cpu_err clear", 32'(cpu_err), 0);
        end

        // fairness: CPU read slips in between two consecutive bursts
        d1 = -1; d2 = -1; bf = -1; pulsed = 1'b0; prev_busy = 1'b0;
        tr_base = 12'h300; tr_req = 1'b1;
        for (int n = 0; n < 60 && d2 < 0; n++) begin
            @(negedge clk);
            cpu_rd = 1'b0;
            if (tr_done) begin
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
            end
            if (prev_busy && !cpu_busy && bf < 0) bf = cyc;
            prev_busy = cpu_busy;
            if (tr_valid && !pulsed) begin
                cpu_rd = 1'b1;
                pulsed = 1'b1;
            end
        end
        tr_req = 1'b0;
        chk("fair cpu done after burst", 32'(bf - d1), 32'd4);
        chk("fair next burst done", 32'(d2 - d1), 32'd9);
        @(negedge clk);

        // strobe while busy is dropped and flags cpu_err; rewind clears it
        cpu_op(0, 8'h00);
        cpu_wr = 1'b1; cpu_din = 8'h77;
        @(negedge clk);
        chk("busy after strobe", 32'(cpu_busy), 1);
        cpu_din = 8'h88;
        @(negedge clk);
        cpu_wr = 1'b0;
        wait_cpu_idle("err test idle");
        chk("first write kept", 32'(mem[0]), 32'h77);
        chk("second write dropped", 32'(mem[1]), 32'h5A);
        chk("cpu_err set", 32'(cpu_err), 1);
        cpu_op(0, 8'h00);
        chk("cpu_err cleared by rewind", 32'(cpu_err), 0);

        // full keymap load with one translator burst injected
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        chk("ld_busy after start", 32'(ld_busy), 1);
        cnt = 0; burst = 1'b0; inj_done = 1'b0;
        for (int n = 0; n < DEPTH + 200 && cnt < DEPTH; n++) begin
            ld_valid = 1'b1;
            ld_data  = pat(cnt);
            if (cnt == 1000 && !inj_done && !burst) begin
                tr_base = 12'h800; tr_req = 1'b1; burst = 1'b1;
            end
            #1;
            if (burst) chk("ld_ready low during burst", 32'(ld_ready), 0);
            else       chk("ld_ready every free cycle", 32'(ld_ready), 1);
            if (burst && tr_done) begin
                tr_req = 1'b0; burst = 1'b0; inj_done = 1'b1;
            end
            if (ld_ready && ld_valid) begin
                chk("load ram_we", 32'(ram_we), 1);
                chk("load ram_addr", 32'(ram_addr), 32'(cnt));
                chk("load ram_wdata", 32'(ram_wdata), 32'(pat(cnt)));
                exp_mem[cnt] = pat(cnt);
                cnt++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("load byte count", 32'(cnt), 32'(DEPTH));
        chk("ld_done pulse", 32'(ld_done), 1);
        chk("ld_busy after load", 32'(ld_busy), 0);
        chk("ld_ready after load", 32'(ld_ready), 0);
        @(negedge clk);
        chk("ld_done one cycle", 32'(ld_done), 0);

        // randomized CPU and translator traffic against the shadow keymap
        fork
            begin : cpu_branch
                int maddr, r;
                logic [7:0] d, exp_dout;
                exp_dout = cpu_dout;
                cpu_op(0, 8'h00);
                maddr = 0;
                repeat (40) begin
                    r = $urandom_range(0, 9);
                    d = 8'($urandom);
                    if (r < 2) begin
                        cpu_op(0, d);
                        maddr = 0;
                    end else if (r < 5) begin
                        cpu_op(2, d);
                        exp_dout = exp_mem[maddr];
                        chk("rand cpu read", 32'(cpu_dout), 32'(exp_dout));
                        maddr = (maddr + 1) & (DEPTH - 1);
                    end else begin
                        cpu_op((r == 9) ? 3 : 1, d);
                        exp_mem[maddr] = d;
                        chk("rand cpu write", 32'(mem[maddr]), 32'(d));
                        chk("rand write keeps dout", 32'(cpu_dout), 32'(exp_dout));
                        maddr = (maddr + 1) & (DEPTH - 1);
                    end
                end
                chk("rand cpu_err", 32'(cpu_err), 0);
            end
            begin : tr_branch
                int beat;
                logic ok;
                logic [11:0] b;
                repeat (12) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    b = 12'($urandom_range(12'h100, 12'hFFF));
                    tr_base = b; tr_req = 1'b1; beat = 0; ok = 1'b0;
                    for (int n = 0; n < 40 && !ok; n++) begin
                        @(negedge clk);
                        if (tr_valid) begin
                            chk("rand tr_idx", 32'(tr_idx), 32'(beat));
                            chk("rand tr_data", 32'(tr_data), 32'(exp_mem[b * 4 + beat]));
                            beat++;
                        end
                        if (tr_done) begin
                            chk("rand beats at done", 32'(beat), 4);
                            tr_req = 1'b0;
                            ok = 1'b1;
                        end
                    end
                    if (!ok) chk("rand burst completes", 32'(ok), 1);
                    tr_req = 1'b0;
                end
            end
        join
        @(negedge clk);

        // walk the CPU address to the top of the keymap, then read across the wrap
        cpu_op(0, 8'h00);
        for (int a = 0; a < DEPTH - 1; a++) cpu_op(1, 8'(a) ^ 8'h3C);
        chk("walk last write", 32'(mem[DEPTH - 2]), 32'(8'(DEPTH - 2) ^ 8'h3C));
        cpu_op(2, 8'h00);
        chk("read at 0x3FFF", 32'(cpu_dout), 32'(pat(DEPTH - 1)));
        cpu_op(2, 8'h00);
        chk("read after wrap", 32'(cpu_dout), 32'h3C);

        // asynchronous reset in the middle of a burst
        tr_base = 12'h111; tr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid-burst tr_valid", 32'(tr_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset tr_valid", 32'(tr_valid), 0);
        chk("async reset ram_addr", 32'(ram_addr), 0);
        chk("async reset tr_done", 32'(tr_done), 0);
        chk("async reset cpu_dout", 32'(cpu_dout), 0);
        tr_req = 1'b0;
        n_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            if (tr_done) n_done++;
        end
        chk("no tr_done after reset", 32'(n_done), 0);
        chk("idle after reset ram_we", 32'(ram_we), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keymap_access_arbiter.md
Name: keymap_access_arbiter

Overview:
Single-port controller for the 16K x 8 keyboard keymap RAM, shared between three requesters:
- the scancode translator (4-byte lookup burst per scancode)
- the CPU keymap register port (auto-incrementing address; read, write, rewind)
- the boot-time keymap loader (byte stream from flash)

The block sits between these requesters and the keymap RAM. It sequences all RAM addresses, write enables and read-data returns.

Parameters:
AW, 14, keymap address width (2^AW bytes)
DW, 8, data width
FAIR, 1, 1 = a pending CPU access is granted before a second consecutive translator burst

Ports:
clk  in  1  system clock (same clock as the PS/2 domain)
rst_n  in  1  reset, asynchronous assert, active low
tr_req  in  1  translator lookup request (level; held until tr_done)
tr_base  in  AW-2  lookup base {modifiers, extended, scan}
tr_valid  out  1  tr_data is valid this cycle
tr_idx  out  2  byte index of tr_data (0..3)
tr_data  out  DW  lookup byte (ram_rdata pass-through)
tr_done  out  1  1-cycle pulse together with tr_idx=3
cpu_rd  in  1  1-cycle read strobe
cpu_wr  in  1  1-cycle write strobe
cpu_din  in  DW  write data, sampled with cpu_wr
cpu_rewind  in  1  1-cycle pulse: CPU address := 0, clears cpu_err
cpu_dout  out  DW  last read byte (registered)
cpu_busy  out  1  CPU access pending or in progress
cpu_err  out  1  sticky: a strobe arrived while cpu_busy=1
ld_start  in  1  1-cycle pulse: start/restart full-keymap load at address 0
ld_valid  in  1  loader byte available
ld_data  in  DW  loader byte
ld_ready  out  1  loader byte accepted when ld_valid & ld_ready
ld_busy  out  1  load in progress
ld_done  out  1  1-cycle pulse after byte 2^AW-1 is written
ram_addr  out  AW  RAM address (combinational from state)
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE
  - all outputs 0, cpu_dout=0
  - CPU address=0, load address=0
  - pending flags cleared, ld_busy=0, last-grant=none
- States: IDLE, TR_ADDR (4 cycles, internal idx 0..3), TR_DRAIN, CPU_RD, CPU_RDDATA, CPU_WR.
- CPU strobes:
  - A cpu_rd/cpu_wr strobe sets cpu_pend (with its type and cpu_din latched) in any state.
  - A strobe received while cpu_busy=1 is dropped and sets cpu_err.
  - Simultaneous cpu_rd and cpu_wr: the write wins.
- IDLE grant priority:
  - Translator (tr_req) first, except FAIR=1 with last grant = translator and cpu_pend=1: then CPU first.
  - CPU second, loader third.
  - ram_we=0 in IDLE unless the loader is granted.
- Translator burst, grant seen in IDLE at cycle T:
  - T+1..T+4: TR_ADDR, ram_addr={tr_base, idx}, idx 0..3.
  - T+2..T+5: tr_valid=1, tr_idx=0..3, tr_data=ram_rdata.
  - T+5: TR_DRAIN, tr_done=1.
  - T+6: IDLE.
  - The burst is never interrupted.
- CPU read: CPU_RD (ram_addr=cpu address), then CPU_RDDATA (cpu_dout<=ram_rdata, address+1, cpu_pend cleared), then IDLE.
- CPU write: CPU_WR (ram_addr=cpu address, ram_we=1, ram_wdata=latched din, address+1, cpu_pend cleared), then IDLE.
- CPU address:
  - Wraps 2^AW-1 -> 0.
  - cpu_rewind zeroes it in any state.
  - Rewind wins over a same-cycle increment.
  - Rewind does not cancel a pending access; that access uses address 0.
- Loader:
  - ld_start sets ld_busy=1 and load address=0; it restarts a load already in progress.
  - ld_ready=1 only in IDLE with ld_busy=1, no tr_req, no cpu_pend.
  - On ld_valid & ld_ready, in the same cycle: ram_addr=load address, ram_we=1, ram_wdata=ld_data.
  - The load address then increments.
  - Writing address 2^AW-1: ld_busy<=0, ld_done pulses next cycle.
- Back-to-back loader bytes are accepted every cycle while nothing else is requested.
- Last-grant updates on each translator or CPU grant. Loader grants do not change it.
- tr_req dropped mid-burst is ignored; the burst completes.
- Reset mid-burst: no tr_done is issued.

Test Plan:
- Reset, then tr_req with tr_base=0x025, RAM preloaded at 0x094..0x097 = {11,22,33,44} -> ram_addr 0x094..0x097 at T+1..T+4; tr_valid T+2..T+5 with data 11,22,33,44; tr_done at T+5; IDLE at T+6.
- cpu_rewind, cpu_wr din=0xA5, cpu_wr din=0x5A, cpu_rewind, two cpu_rd -> writes to 0x0000 and 0x0001; reads return cpu_dout=0xA5 then 0x5A; cpu_err=0.
- FAIR=1: tr_req held continuously, cpu_rd pulsed during the first burst -> CPU_RD granted immediately after that burst's TR_DRAIN; next burst follows.
- ld_start, 16384 bytes with ld_valid=1 and no other requests -> one write per cycle to 0x0000..0x3FFF; ld_done pulse; ld_busy=0; ld_ready low during any injected tr_req burst.
- cpu_wr issued, then a second cpu_wr while cpu_busy=1 -> only the first write reaches RAM; cpu_err=1; a following cpu_rewind clears cpu_err.
- CPU address at 0x3FFF, cpu_rd -> reads 0x3FFF, next address 0x0000; rst_n asserted low mid-burst -> outputs 0 asynchronously, no tr_done.
